// File: rtl/ex_multicycle_unit.sv
// Iterative multiply/divide unit beside the EX-stage ALU; stalls EX while busy.
// Ports: clk, reset, start, op_sel, a, b, hold, flush -> result, done, ex_mc_stall,
// div_by_zero, illegal_op. Divide datapath present only when EX_MC_DIV_EN is defined.
module ex_multicycle_unit #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hold,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             ex_mc_stall,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int B  = BITS_PER_CYCLE;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / B - 1);
`ifdef EX_MC_DIV_EN
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
`endif

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             op_hi;
  logic [WIDTH-1:0] b_r;
  // q_r: multiplier (low product bits shift in) or dividend/quotient.
  // hi_r: upper product half or partial remainder.
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] result_r;
  logic             done_r;

  logic [WIDTH+B-1:0] sum;
  logic [WIDTH-1:0]   mul_hi;
  logic [WIDTH-1:0]   mul_lo;
  logic [WIDTH-1:0]   nx_hi;
  logic [WIDTH-1:0]   nx_q;
  logic [WIDTH-1:0]   fin;

`ifdef EX_MC_DIV_EN
  logic             is_div;
  logic             dbz_r;
  logic [WIDTH:0]   r2;
  logic             ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_q;
`else
  logic             ill_r;
`endif

  always_comb begin
    sum    = {{B{1'b0}}, hi_r}
           + ({{B{1'b0}}, b_r} * {{WIDTH{1'b0}}, q_r[B-1:0]});
    mul_hi = sum[WIDTH+B-1:B];
    mul_lo = WIDTH'({sum[B-1:0], q_r} >> B);
    nx_hi  = mul_hi;
    nx_q   = mul_lo;
`ifdef EX_MC_DIV_EN
    r2      = {hi_r, q_r[WIDTH-1]};
    ge      = (r2 >= {1'b0, b_r});
    div_rem = WIDTH'(ge ? r2 - {1'b0, b_r} : r2);
    div_q   = {q_r[WIDTH-2:0], ge};
    if (is_div) begin
      nx_hi = div_rem;
      nx_q  = div_q;
    end
`endif
    // bit 0 of op_sel picks MULHI / DIVR, both live in hi_r
    fin = op_hi ? nx_hi : nx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_hi    <= 1'b0;
      b_r      <= '0;
      q_r      <= '0;
      hi_r     <= '0;
      result_r <= '0;
      done_r   <= 1'b0;
`ifdef EX_MC_DIV_EN
      is_div   <= 1'b0;
      dbz_r    <= 1'b0;
`else
      ill_r    <= 1'b0;
`endif
    end else if (flush) begin
      state    <= IDLE;
      result_r <= '0;
      done_r   <= 1'b0;
`ifdef EX_MC_DIV_EN
      dbz_r    <= 1'b0;
`else
      ill_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_hi <= op_sel[0];
            b_r   <= b;
            q_r   <= a;
            hi_r  <= '0;
            if (op_sel[1]) begin
`ifdef EX_MC_DIV_EN
              is_div <= 1'b1;
              cnt    <= DIV_LAST;
              if (b == '0) begin
                state    <= DONE;
                done_r   <= 1'b1;
                dbz_r    <= 1'b1;
                result_r <= op_sel[0] ? a : '1;
              end else begin
                state <= BUSY;
              end
`else
              state    <= DONE;
              done_r   <= 1'b1;
              ill_r    <= 1'b1;
              result_r <= '0;
`endif
            end else begin
`ifdef EX_MC_DIV_EN
              is_div <= 1'b0;
`endif
              cnt   <= MUL_LAST;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          hi_r <= nx_hi;
          q_r  <= nx_q;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) begin
            state    <= DONE;
            done_r   <= 1'b1;
            result_r <= fin;
          end
        end
        DONE: begin
          if (!hold) begin
            state    <= IDLE;
            done_r   <= 1'b0;
            result_r <= '0;
`ifdef EX_MC_DIV_EN
            dbz_r    <= 1'b0;
`else
            ill_r    <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result      = result_r;
  assign done        = done_r;
  assign ex_mc_stall = ((state == IDLE) & start & ~flush) | (state == BUSY);
`ifdef EX_MC_DIV_EN
  assign div_by_zero = dbz_r;
  assign illegal_op  = 1'b0;
`else
  assign div_by_zero = 1'b0;
  assign illegal_op  = ill_r;
`endif

endmodule
